dac_sampler: RTL and testbench
==============================

DAC_SAMPLER -- requirements
Module: dac_sampler

Interface
REQ-001 The module SHALL have parameter WIDTH, default 12, giving the DAC code width in bits.
REQ-002 The module SHALL have parameter VREF, real, default 3.3, giving the full-scale reference voltage in volts.
REQ-003 The module SHALL have parameter TICK_DIV, integer, default 100, giving the number of clk cycles per sample update (1 MHz at 100 MHz clk); legal range is 2 or more.
REQ-004 Port clk, input, 1 bit: single system clock, rising-edge active (100 MHz nominal).
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port en, input, 1 bit: enables the tick counter; when low, the counter holds.
REQ-007 Port I_data, input, WIDTH bits: unsigned digital sample to convert.
REQ-008 Port tick, output, 1 bit: sample-update strobe, one clk cycle wide.
REQ-009 Port code_q, output, WIDTH bits: the currently held DAC code.
REQ-010 Port A_out, output, real (SystemVerilog real port): modelled analog output voltage.

Function
REQ-011 The tick counter SHALL count 0 to TICK_DIV-1 on each rising clk edge while en=1, and wrap to 0 after TICK_DIV-1.
REQ-012 When en=0, the counter SHALL hold its value and tick SHALL be 0.
REQ-013 tick SHALL be combinational: 1 exactly when en=1 and count==TICK_DIV-1, else 0.
REQ-014 On a rising clk edge with tick=1, code_q SHALL load I_data; otherwise code_q SHALL hold.
REQ-015 I_data SHALL be sampled only at tick edges; changes between ticks SHALL NOT affect code_q or A_out.
REQ-016 A_out SHALL equal VREF * code_q / 2**WIDTH, computed in real arithmetic and updated in the same time step as code_q (zero added latency).
REQ-017 Code 0 SHALL map to 0.0 V and code 2**WIDTH-1 to VREF*(2**WIDTH-1)/2**WIDTH; no saturation logic is needed because the code cannot exceed the range.
REQ-018 With en held at 1 from reset release, the first update SHALL occur on the TICK_DIV-th rising edge after release, then every TICK_DIV edges.
REQ-019 If en drops mid-count and later returns to 1, counting SHALL resume from the held value, with no extra or lost tick.

Reset
REQ-020 While rst=1: count=0, code_q=0, A_out=0.0, tick=0, regardless of clk.
REQ-021 Reset asserted mid-interval SHALL discard the partial count; after release, the next tick SHALL be TICK_DIV edges later.

Structure
REQ-022 A shared package SHALL hold DAC_WIDTH=12, DEFAULT_VREF=3.3 and DEFAULT_TICK_DIV=100.
REQ-023 The tick counter SHALL be a separate sub-module, tick_counter, with ports clk, rst, en, tick and parameter TICK_DIV; dac_sampler instantiates it.
REQ-024 Clock generation SHALL NOT be part of the block; the clock is supplied by the environment.

Verification
REQ-025 Reset then en=1, I_data=4000 held, clk 10 ns: code_q=0 and A_out=0.0 for the first 99 edges; at edge 100 (t=1 us after release), code_q=4000 and A_out=3.22265625 V.
REQ-026 Run 400 us with en=1: exactly 400 tick pulses, each 1 cycle wide and spaced 100 cycles apart.
REQ-027 Change I_data 1000 -> 500 between ticks: A_out stays at 0.8056640625 V until the next tick, then becomes 0.40283203125 V.
REQ-028 I_data=4095, then 0: A_out=3.299194335937 V, then exactly 0.0 V.
REQ-029 en=0 for 250 cycles mid-count at count=40: no tick during that time; after en returns to 1, the tick arrives 59 edges later.
REQ-030 Assert rst asynchronously (between clk edges) at count=70 with code_q=4000: outputs clear immediately; after release, the first tick is 100 edges later.

Source files
------------

// File: rtl/dac_sampler_pkg.sv
// Shared constants for the DAC sampler and its tick counter.
package dac_sampler_pkg;

  localparam int unsigned DAC_WIDTH        = 12;
  localparam real         DEFAULT_VREF     = 3.3;
  localparam int unsigned DEFAULT_TICK_DIV = 100;

endpackage

// File: rtl/tick_counter.sv
// Free-running divide-by-TICK_DIV counter producing a one-cycle sample strobe.
// The counter pauses while en is low. The strobe is combinational, so it is
// never asserted while en is low.
module tick_counter
  import dac_sampler_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  // Terminal-count decode and the enable-qualified strobe.
  always_comb begin
    w_last = (r_count == LAST);
    tick   = en & w_last;
  end

  // Count 0..TICK_DIV-1 while enabled and wrap; hold the value while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/dac_sampler.sv
// Sample-and-hold DAC model. I_data is captured on each tick edge, and the
// held code is converted to a modelled analog voltage A_out.
module dac_sampler
  import dac_sampler_pkg::*;
#(
  parameter int unsigned WIDTH    = DAC_WIDTH,
  parameter real         VREF     = DEFAULT_VREF,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] I_data,
  output logic             tick,
  output logic [WIDTH-1:0] code_q,
  output real              A_out
);

  localparam real FULL_SCALE = 2.0 ** WIDTH;

  logic             w_tick;
  logic [WIDTH-1:0] r_code;

  tick_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (w_tick)
  );

  // Hold register: load the input sample only on a tick edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= '0;
    end else if (w_tick) begin
      r_code <= I_data;
    end
  end

  // Drive the outputs. The voltage tracks the held code with no added
  // latency, and it reads 0.0 V while in reset.
  always_comb begin
    tick   = w_tick;
    code_q = r_code;
    A_out  = VREF * real'(r_code) / FULL_SCALE;
  end

endmodule

// File: tb/tb_dac_sampler.sv
// Self-checking bench for dac_sampler. Uses randomized stimulus against a
// behavioural model of the sampling rules.
module tb_dac_sampler;
  import dac_sampler_pkg::*;

  localparam int unsigned W  = DAC_WIDTH;
  localparam int unsigned TD = DEFAULT_TICK_DIV;
  localparam real         VR = DEFAULT_VREF;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] I_data;
  logic         tick;
  logic [W-1:0] code_q;
  real          A_out;

  int n_vec = 0;
  int n_err = 0;

  // Model state: enabled edges taken modulo TD, plus the last loaded sample.
  int m_count;
  int m_code;

  always #5 clk = ~clk;

  dac_sampler #(
    .WIDTH    (W),
    .VREF     (VR),
    .TICK_DIV (TD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .I_data (I_data),
    .tick   (tick),
    .code_q (code_q),
    .A_out  (A_out)
  );

  function automatic real volts(input int code);
    return VR * real'(code) / (2.0 ** W);
  endfunction

  task automatic check_val(input string tag, input real obs, input real exp);
    n_vec++;
    if ((obs - exp > 1.0e-9) || (exp - obs > 1.0e-9)) begin
      n_err++;
      $display("FAIL %s: got %0.12f expected %0.12f at %0t", tag, obs, exp, $time);
    end
  endtask

  // Run one clock cycle. Check tick before the edge, then check code_q and
  // A_out after it.
  task automatic cycle(input logic e, input logic [W-1:0] d, output bit t, output bit dt);
    @(negedge clk);
    en     = e;
    I_data = d;
    #1;
    t  = e && (m_count == TD - 1);
    dt = tick;
    check_val("tick", real'(tick), t ? 1.0 : 0.0);
    @(posedge clk);
    if (t) m_code = int'(d);
    if (e) m_count = (m_count + 1) % TD;
    #1;
    check_val("code_q", real'(code_q), real'(m_code));
    check_val("A_out", A_out, volts(m_code));
  endtask

  // Run enabled cycles until the DUT raises tick. Returns the call index of
  // that cycle, or 0 if the budget is exhausted.
  task automatic run_to_tick(input logic [W-1:0] d, input int budget, output int k);
    bit t, dt;
    k = 0;
    for (int i = 1; i <= budget; i++) begin
      cycle(1'b1, d, t, dt);
      if (dt) begin
        k = i;
        break;
      end
    end
  endtask

  // Assert reset between clock edges and check that the outputs clear
  // immediately. Release reset at the next falling edge with en low.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    m_count = 0;
    m_code  = 0;
    check_val("rst_code_q", real'(code_q), 0.0);
    check_val("rst_A_out", A_out, 0.0);
    check_val("rst_tick", real'(tick), 0.0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    bit t, dt;
    int k, n_ticks, last_i;

    rst = 1'b1; en = 1'b0; I_data = '0;
    m_count = 0; m_code = 0;

    // Hold reset while the clock toggles.
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    #1;
    check_val("init_code_q", real'(code_q), 0.0);
    check_val("init_A_out", A_out, 0.0);
    check_val("init_tick", real'(tick), 0.0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;

    // First update lands on the 100th enabled edge after release.
    for (int i = 1; i <= int'(TD); i++) begin
      cycle(1'b1, W'(4000), t, dt);
      if (i == int'(TD) - 1) check_val("pre_first_code", real'(code_q), 0.0);
    end
    check_val("first_code", real'(code_q), 4000.0);
    check_val("first_A_out", A_out, 3.22265625);

    // 400 us of continuous enable with random data.
    n_ticks = 0; last_i = 0;
    for (int i = 1; i <= 400 * int'(TD); i++) begin
      cycle(1'b1, W'($urandom), t, dt);
      if (dt) begin
        if (n_ticks > 0) check_val("tick_gap", real'(i - last_i), real'(TD));
        n_ticks++;
        last_i = i;
      end
    end
    check_val("tick_count_400us", real'(n_ticks), 400.0);

    // The input changes between ticks must not reach the output.
    run_to_tick(W'(1000), 2 * TD, k);
    check_val("load_1000", A_out, 0.8056640625);
    repeat (20) cycle(1'b1, W'(1000), t, dt);
    repeat (30) cycle(1'b1, W'(500), t, dt);
    check_val("hold_1000", A_out, 0.8056640625);
    run_to_tick(W'(500), 2 * TD, k);
    check_val("load_500", A_out, 0.40283203125);

    // Full-scale code, then zero.
    run_to_tick(W'(4095), 2 * TD, k);
    check_val("full_scale", A_out, 3.299194335937);
    run_to_tick(W'(0), 2 * TD, k);
    check_val("zero_scale", A_out, 0.0);

    // Disable at count 40 for 250 cycles. Counting resumes from 40.
    for (int i = 0; i < 2 * int'(TD) && m_count != 40; i++) cycle(1'b1, W'($urandom), t, dt);
    n_ticks = 0;
    for (int i = 0; i < 250; i++) begin
      cycle(1'b0, W'($urandom), t, dt);
      if (dt) n_ticks++;
    end
    check_val("ticks_while_disabled", real'(n_ticks), 0.0);
    run_to_tick(W'($urandom), 2 * TD, k);
    check_val("edges_to_tick_after_resume", real'(k - 1), 59.0);

    // Asynchronous reset mid-interval with code 4000 held.
    run_to_tick(W'(4000), 2 * TD, k);
    for (int i = 0; i < 2 * int'(TD) && m_count != 70; i++) cycle(1'b1, W'(4000), t, dt);
    check_val("pre_reset_code", real'(code_q), 4000.0);
    async_reset();
    run_to_tick(W'(1234), 2 * TD, k);
    check_val("edges_to_load_after_reset", real'(k), real'(TD));

    // Random enable, random data, occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 80), W'($urandom), t, dt);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
